cell_protect_engine: RTL and testbench

Parametrised RTL cell-voltage protection engine, the synthesizable successor to the behavioural BQ76952 model's COV/CUV/COVL checks. It round-robin scans N_CELLS cell voltages and tracks per-scan max/min. It runs independent over-voltage and under-voltage alert/trip state machines with delay counting and recovery hysteresis, plus a latched-OV counter. It sits between the cell ADC result registers and the CHG/DSG FET drive logic.

---
 rtl/cell_protect_engine.sv | 216 +++++++++++++++++++++
 tb/tb_cell_protect_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_protect_engine.sv
// Round-robin cell-voltage scanner with per-scan max/min, OV/UV alert/trip FSMs,
// latched-OV occurrence counter and CHG/DSG FET enable generation.
module cell_protect_engine #(
    parameter int unsigned N_CELLS = 16,
    parameter int unsigned VW      = 16,
    parameter int unsigned DLY_W   = 8,
    parameter int unsigned LATCH_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CELLS*VW-1:0]       i_cell_v,
    input  logic [N_CELLS-1:0]          i_cell_en,
    input  logic [VW-1:0]               i_ov_th,
    input  logic [VW-1:0]               i_ov_rec,
    input  logic [VW-1:0]               i_uv_th,
    input  logic [VW-1:0]               i_uv_rec,
    input  logic [DLY_W-1:0]            i_ov_dly,
    input  logic [DLY_W-1:0]            i_uv_dly,
    input  logic [LATCH_W-1:0]          i_covl_limit,
    input  logic                        i_covl_clear,
    output logic [VW-1:0]               o_max_v,
    output logic [VW-1:0]               o_min_v,
    output logic [$clog2(N_CELLS)-1:0]  o_max_idx,
    output logic [$clog2(N_CELLS)-1:0]  o_min_idx,
    output logic                        o_scan_done,
    output logic                        o_ov_alert,
    output logic                        o_uv_alert,
    output logic                        o_ov_fault,
    output logic                        o_uv_fault,
    output logic                        o_covl_latched,
    output logic                        o_chg_en,
    output logic                        o_dsg_en,
    output logic                        o_alert
);

    localparam int unsigned IW = $clog2(N_CELLS);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_ALERT  = 2'd1,
        ST_TRIP   = 2'd2
    } state_t;

    // One commit step of an alert/trip FSM: returns {next_state, next_count}.
    function automatic logic [DLY_W+1:0] f_step(
        input state_t           st,
        input logic [DLY_W-1:0] cnt,
        input logic             hit,
        input logic             rec,
        input logic [DLY_W-1:0] dly
    );
        logic [DLY_W-1:0] eff;
        logic [DLY_W:0]   inc;
        eff    = (dly == '0) ? DLY_W'(1) : dly;
        inc    = {1'b0, cnt} + (DLY_W+1)'(1);
        f_step = {ST_NORMAL, DLY_W'(0)};
        case (st)
            ST_NORMAL: if (hit) f_step = (eff == DLY_W'(1)) ? {ST_TRIP, DLY_W'(0)}
                                                            : {ST_ALERT, DLY_W'(1)};
            ST_ALERT:  if (hit) f_step = (inc >= {1'b0, eff}) ? {ST_TRIP, DLY_W'(0)}
                                                              : {ST_ALERT, inc[DLY_W-1:0]};
            ST_TRIP:   if (!rec) f_step = {ST_TRIP, DLY_W'(0)};
            default:   f_step = {ST_NORMAL, DLY_W'(0)};
        endcase
    endfunction

    logic [IW-1:0]      r_idx;
    logic [VW-1:0]      r_run_max, r_run_min;
    logic [IW-1:0]      r_run_max_idx, r_run_min_idx;
    logic               r_run_any;
    logic [VW-1:0]      r_max_v, r_min_v;
    logic [IW-1:0]      r_max_idx, r_min_idx;
    logic               r_scan_done, r_valid;
    state_t             r_ov_state, r_uv_state;
    logic [DLY_W-1:0]   r_ov_cnt, r_uv_cnt;
    logic [LATCH_W-1:0] r_occ;
    logic               r_covl;
    logic               r_ov_alert, r_uv_alert, r_ov_fault, r_uv_fault;
    logic               r_chg_en, r_dsg_en, r_alert;

    logic [VW-1:0]      w_cur_v;
    logic               w_cur_en, w_last;
    logic               w_take_max, w_take_min;
    logic [VW-1:0]      w_new_max, w_new_min;
    logic [IW-1:0]      w_new_max_idx, w_new_min_idx;
    logic               w_new_any, w_step;
    logic [DLY_W+1:0]   w_ov_nx, w_uv_nx;
    state_t             w_ov_state_nx, w_uv_state_nx;
    logic               w_ov_enter;
    logic [LATCH_W-1:0] w_occ_inc;
    logic               w_latch_nx, w_valid_nx;
    logic               w_ov_fault_nx, w_uv_fault_nx, w_ov_alert_nx, w_uv_alert_nx;

    // Current cell and running max/min including it; first enabled cell seeds both.
    always_comb begin
        w_cur_v       = VW'(i_cell_v >> (r_idx * VW));
        w_cur_en      = i_cell_en[r_idx];
        w_last        = (r_idx == IW'(N_CELLS - 1));
        w_take_max    = w_cur_en & (~r_run_any | (w_cur_v > r_run_max));
        w_take_min    = w_cur_en & (~r_run_any | (w_cur_v < r_run_min));
        w_new_max     = w_take_max ? w_cur_v : r_run_max;
        w_new_min     = w_take_min ? w_cur_v : r_run_min;
        w_new_max_idx = w_take_max ? r_idx : r_run_max_idx;
        w_new_min_idx = w_take_min ? r_idx : r_run_min_idx;
        w_new_any     = r_run_any | w_cur_en;
        w_step        = w_last & w_new_any;
    end

    // FSM next state is only evaluated at a commit with at least one enabled cell.
    always_comb begin
        w_ov_nx = {r_ov_state, r_ov_cnt};
        w_uv_nx = {r_uv_state, r_uv_cnt};
        if (w_step) begin
            w_ov_nx = f_step(r_ov_state, r_ov_cnt, w_new_max >= i_ov_th,
                             w_new_max <= i_ov_rec, i_ov_dly);
            w_uv_nx = f_step(r_uv_state, r_uv_cnt, w_new_min <= i_uv_th,
                             w_new_min >= i_uv_rec, i_uv_dly);
        end
        w_ov_state_nx = state_t'(w_ov_nx[DLY_W +: 2]);
        w_uv_state_nx = state_t'(w_uv_nx[DLY_W +: 2]);
        w_ov_enter    = (r_ov_state != ST_TRIP) && (w_ov_state_nx == ST_TRIP);
        w_occ_inc     = (r_occ == '1) ? r_occ : r_occ + LATCH_W'(1);
        w_latch_nx    = ~i_covl_clear & (r_covl | (w_ov_enter & (i_covl_limit != '0) &
                                                  (w_occ_inc >= i_covl_limit)));
        w_valid_nx    = r_valid | w_last;
        w_ov_fault_nx = (w_ov_state_nx == ST_TRIP);
        w_uv_fault_nx = (w_uv_state_nx == ST_TRIP);
        w_ov_alert_nx = (w_ov_state_nx == ST_ALERT);
        w_uv_alert_nx = (w_uv_state_nx == ST_ALERT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_run_max     <= '0;
            r_run_min     <= '1;
            r_run_max_idx <= '0;
            r_run_min_idx <= '0;
            r_run_any     <= 1'b0;
            r_max_v       <= '0;
            r_min_v       <= '1;
            r_max_idx     <= '0;
            r_min_idx     <= '0;
            r_scan_done   <= 1'b0;
            r_valid       <= 1'b0;
            r_ov_state    <= ST_NORMAL;
            r_uv_state    <= ST_NORMAL;
            r_ov_cnt      <= '0;
            r_uv_cnt      <= '0;
            r_occ         <= '0;
            r_covl        <= 1'b0;
            r_ov_alert    <= 1'b0;
            r_uv_alert    <= 1'b0;
            r_ov_fault    <= 1'b0;
            r_uv_fault    <= 1'b0;
            r_chg_en      <= 1'b0;
            r_dsg_en      <= 1'b0;
            r_alert       <= 1'b0;
        end else begin
            r_idx       <= w_last ? '0 : r_idx + IW'(1);
            r_scan_done <= w_last;
            if (w_last) begin
                r_max_v       <= w_new_max;
                r_min_v       <= w_new_min;
                r_max_idx     <= w_new_max_idx;
                r_min_idx     <= w_new_min_idx;
                r_run_max     <= '0;
                r_run_min     <= '1;
                r_run_max_idx <= '0;
                r_run_min_idx <= '0;
                r_run_any     <= 1'b0;
            end else begin
                r_run_max     <= w_new_max;
                r_run_min     <= w_new_min;
                r_run_max_idx <= w_new_max_idx;
                r_run_min_idx <= w_new_min_idx;
                r_run_any     <= w_new_any;
            end
            r_ov_state <= w_ov_state_nx;
            r_uv_state <= w_uv_state_nx;
            r_ov_cnt   <= w_ov_nx[DLY_W-1:0];
            r_uv_cnt   <= w_uv_nx[DLY_W-1:0];
            // Clear wins over a same-cycle trip increment.
            if (i_covl_clear) begin
                r_occ <= '0;
            end else if (w_ov_enter) begin
                r_occ <= w_occ_inc;
            end
            r_covl     <= w_latch_nx;
            r_valid    <= w_valid_nx;
            r_ov_alert <= w_ov_alert_nx;
            r_uv_alert <= w_uv_alert_nx;
            r_ov_fault <= w_ov_fault_nx;
            r_uv_fault <= w_uv_fault_nx;
            r_chg_en   <= w_valid_nx & ~w_ov_fault_nx & ~w_latch_nx;
            r_dsg_en   <= w_valid_nx & ~w_uv_fault_nx;
            r_alert    <= w_ov_alert_nx | w_uv_alert_nx | w_ov_fault_nx |
                          w_uv_fault_nx | w_latch_nx;
        end
    end

    assign o_max_v        = r_max_v;
    assign o_min_v        = r_min_v;
    assign o_max_idx      = r_max_idx;
    assign o_min_idx      = r_min_idx;
    assign o_scan_done    = r_scan_done;
    assign o_ov_alert     = r_ov_alert;
    assign o_uv_alert     = r_uv_alert;
    assign o_ov_fault     = r_ov_fault;
    assign o_uv_fault     = r_uv_fault;
    assign o_covl_latched = r_covl;
    assign o_chg_en       = r_chg_en;
    assign o_dsg_en       = r_dsg_en;
    assign o_alert        = r_alert;

endmodule

// File: tb/tb_cell_protect_engine.sv
// Self-checking bench for cell_protect_engine: scan-level behavioural model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_cell_protect_engine;

    localparam int unsigned N  = 16;
    localparam int unsigned VW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 4;
    localparam int unsigned IW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N*VW-1:0]   cell_v;
    logic [N-1:0]      cell_en;
    logic [VW-1:0]     ov_th, ov_rec, uv_th, uv_rec;
    logic [DW-1:0]     ov_dly, uv_dly;
    logic [LW-1:0]     covl_limit;
    logic              covl_clear;
    logic [VW-1:0]     max_v, min_v;
    logic [IW-1:0]     max_idx, min_idx;
    logic              scan_done, ov_alert, uv_alert, ov_fault, uv_fault;
    logic              covl_latched, chg_en, dsg_en, alert;

    always #5 clk = ~clk;

    cell_protect_engine #(.N_CELLS(N), .VW(VW), .DLY_W(DW), .LATCH_W(LW)) dut (
        .clk(clk), .rst(rst),
        .i_cell_v(cell_v), .i_cell_en(cell_en),
        .i_ov_th(ov_th), .i_ov_rec(ov_rec), .i_uv_th(uv_th), .i_uv_rec(uv_rec),
        .i_ov_dly(ov_dly), .i_uv_dly(uv_dly),
        .i_covl_limit(covl_limit), .i_covl_clear(covl_clear),
        .o_max_v(max_v), .o_min_v(min_v), .o_max_idx(max_idx), .o_min_idx(min_idx),
        .o_scan_done(scan_done), .o_ov_alert(ov_alert), .o_uv_alert(uv_alert),
        .o_ov_fault(ov_fault), .o_uv_fault(uv_fault), .o_covl_latched(covl_latched),
        .o_chg_en(chg_en), .o_dsg_en(dsg_en), .o_alert(alert)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: samples one cell per clock, and on the last cell of a scan
    // recomputes max/min over the sampled values and steps consecutive-scan counters.
    int m_pos;
    int m_val [N];
    bit m_en  [N];
    int e_max, e_min, e_maxi, e_mini;
    bit e_done, e_ova, e_uva, e_chg, e_dsg, e_alert;
    int ov_run, uv_run, occ;
    bit ov_trip, uv_trip, latched, valid;
    bit s_any;
    int s_mx, s_mn, s_mxi, s_mni;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos = 0; e_max = 0; e_min = 65535; e_maxi = 0; e_mini = 0; e_done = 0;
            ov_run = 0; uv_run = 0; occ = 0; ov_trip = 0; uv_trip = 0;
            latched = 0; valid = 0;
        end else begin
            m_val[m_pos] = int'(cell_v[m_pos*VW +: VW]);
            m_en[m_pos]  = cell_en[m_pos];
            e_done = 0;
            if (m_pos == N - 1) begin
                s_any = 0; s_mx = 0; s_mn = 65535; s_mxi = 0; s_mni = 0;
                for (int i = 0; i < N; i++) begin
                    if (m_en[i]) begin
                        if (!s_any || m_val[i] > s_mx) begin s_mx = m_val[i]; s_mxi = i; end
                        if (!s_any || m_val[i] < s_mn) begin s_mn = m_val[i]; s_mni = i; end
                        s_any = 1;
                    end
                end
                e_max = s_mx; e_min = s_mn; e_maxi = s_mxi; e_mini = s_mni;
                e_done = 1; valid = 1;
                if (s_any) begin
                    if (!ov_trip) begin
                        if (s_mx >= int'(ov_th)) begin
                            ov_run++;
                            if (ov_run >= eff(int'(ov_dly))) begin
                                ov_trip = 1; ov_run = 0;
                                if (occ < 15) occ++;
                                if (covl_limit != 0 && occ >= int'(covl_limit)) latched = 1;
                            end
                        end else ov_run = 0;
                    end else if (s_mx <= int'(ov_rec)) ov_trip = 0;
                    if (!uv_trip) begin
                        if (s_mn <= int'(uv_th)) begin
                            uv_run++;
                            if (uv_run >= eff(int'(uv_dly))) begin uv_trip = 1; uv_run = 0; end
                        end else uv_run = 0;
                    end else if (s_mn >= int'(uv_rec)) uv_trip = 0;
                end
            end
            if (covl_clear) begin occ = 0; latched = 0; end
            m_pos = (m_pos + 1) % N;
        end
        e_ova   = !ov_trip && ov_run > 0;
        e_uva   = !uv_trip && uv_run > 0;
        e_chg   = valid && !ov_trip && !latched;
        e_dsg   = valid && !uv_trip;
        e_alert = e_ova || e_uva || ov_trip || uv_trip || latched;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("max_v", int'(max_v), e_max);
            chk("min_v", int'(min_v), e_min);
            chk("max_idx", int'(max_idx), e_maxi);
            chk("min_idx", int'(min_idx), e_mini);
            chk("scan_done", int'(scan_done), int'(e_done));
            chk("ov_alert", int'(ov_alert), int'(e_ova));
            chk("uv_alert", int'(uv_alert), int'(e_uva));
            chk("ov_fault", int'(ov_fault), int'(ov_trip));
            chk("uv_fault", int'(uv_fault), int'(uv_trip));
            chk("covl_latched", int'(covl_latched), int'(latched));
            chk("chg_en", int'(chg_en), int'(e_chg));
            chk("dsg_en", int'(dsg_en), int'(e_dsg));
            chk("alert", int'(alert), int'(e_alert));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_cell(input int i, input int v);
        cell_v[i*VW +: VW] = VW'(v);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2 * N + 4 && !seen; k++) begin
            tick(1);
            seen = scan_done;
        end
        if (!seen) chk({"timeout_", tag}, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_cell(i, 4000);
        cell_en = '1; ov_th = 16'd4500; ov_rec = 16'd4300; uv_th = 16'd2800; uv_rec = 16'd3000;
        ov_dly = 8'd3; uv_dly = 8'd0; covl_limit = 4'd0; covl_clear = 1'b0;
        #1 rst = 1'b1;
        chk_on = 1'b1;
        tick(3);
        chk("rst_max_v", int'(max_v), 0);
        chk("rst_min_v", int'(min_v), 65535);
        chk("rst_chg_en", int'(chg_en), 0);
        rst = 1'b0;

        // Baseline: first commit exactly N cycles after release.
        tick(15);
        chk("pre_done", int'(scan_done), 0);
        chk("pre_dsg_en", int'(dsg_en), 0);
        tick(1);
        chk("first_done", int'(scan_done), 1);
        chk("first_max", int'(max_v), 4000);
        chk("first_min", int'(min_v), 4000);
        chk("tie_max_idx", int'(max_idx), 0);
        chk("tie_min_idx", int'(min_idx), 0);
        chk("first_chg", int'(chg_en), 1);
        chk("first_dsg", int'(dsg_en), 1);
        chk("first_alert", int'(alert), 0);

        // OV with delay 3, then hysteresis recovery.
        set_cell(0, 5500);
        wait_done("ov1");
        chk("ov_c1_alert", int'(ov_alert), 1);
        chk("ov_c1_fault", int'(ov_fault), 0);
        wait_done("ov2");
        chk("ov_c2_fault", int'(ov_fault), 0);
        wait_done("ov3");
        chk("ov_c3_fault", int'(ov_fault), 1);
        chk("ov_c3_chg", int'(chg_en), 0);
        chk("ov_c3_maxidx", int'(max_idx), 0);
        set_cell(0, 4400);
        wait_done("ov4");
        chk("ov_hyst_fault", int'(ov_fault), 1);
        set_cell(0, 4200);
        wait_done("ov5");
        chk("ov_rec_fault", int'(ov_fault), 0);
        chk("ov_rec_chg", int'(chg_en), 1);

        // UV with delay 0 behaving as 1.
        set_cell(1, 2500);
        wait_done("uv1");
        chk("uv_fault", int'(uv_fault), 1);
        chk("uv_dsg", int'(dsg_en), 0);
        chk("uv_min", int'(min_v), 2500);
        chk("uv_min_idx", int'(min_idx), 1);
        set_cell(1, 4000);
        wait_done("uv2");
        chk("uv_rec_fault", int'(uv_fault), 0);
        chk("uv_rec_dsg", int'(dsg_en), 1);

        // Latched OV after two trips.
        covl_clear = 1'b1;
        tick(1);
        covl_clear = 1'b0;
        covl_limit = 4'd2; ov_dly = 8'd1;
        wait_done("align");
        set_cell(0, 5500);
        wait_done("covl1");
        chk("covl_t1_fault", int'(ov_fault), 1);
        chk("covl_t1_latch", int'(covl_latched), 0);
        set_cell(0, 4000);
        wait_done("covl2");
        chk("covl_r1_chg", int'(chg_en), 1);
        set_cell(0, 5500);
        wait_done("covl3");
        chk("covl_t2_latch", int'(covl_latched), 1);
        set_cell(0, 4000);
        wait_done("covl4");
        chk("covl_r2_fault", int'(ov_fault), 0);
        chk("covl_r2_latch", int'(covl_latched), 1);
        chk("covl_r2_chg", int'(chg_en), 0);
        tick(3);
        covl_clear = 1'b1;
        tick(1);
        chk("covl_clr_latch", int'(covl_latched), 0);
        chk("covl_clr_chg", int'(chg_en), 1);
        covl_clear = 1'b0;

        // Disabled cells ignored; all-disabled scan holds FSM state.
        cell_en = 16'hFFFE;
        set_cell(0, 5500);
        wait_done("en0");
        wait_done("en1");
        chk("mask_ov_alert", int'(ov_alert), 0);
        chk("mask_ov_fault", int'(ov_fault), 0);
        chk("mask_max", int'(max_v), 4000);
        chk("mask_max_idx", int'(max_idx), 1);
        ov_dly = 8'd3;
        set_cell(1, 5500);
        wait_done("en2");
        chk("c1_ov_alert", int'(ov_alert), 1);
        chk("c1_max_idx", int'(max_idx), 1);
        cell_en = '0;
        wait_done("en3");
        chk("none_max", int'(max_v), 0);
        chk("none_min", int'(min_v), 65535);
        chk("none_hold_alert", int'(ov_alert), 1);
        chk("none_hold_fault", int'(ov_fault), 0);
        cell_en = '1;
        set_cell(0, 4000);
        set_cell(1, 4000);
        wait_done("en4");
        chk("restore_alert", int'(ov_alert), 0);
        chk("restore_max", int'(max_v), 4000);

        // Reset mid-scan.
        tick(8);
        rst = 1'b1;
        #1;
        chk("mid_rst_chg", int'(chg_en), 0);
        chk("mid_rst_dsg", int'(dsg_en), 0);
        chk("mid_rst_max", int'(max_v), 0);
        chk("mid_rst_min", int'(min_v), 65535);
        tick(1);
        rst = 1'b0;
        tick(15);
        chk("post_rst_pre_done", int'(scan_done), 0);
        tick(1);
        chk("post_rst_done", int'(scan_done), 1);
        chk("post_rst_max", int'(max_v), 4000);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
